seq_shift_add_multiplier: RTL and testbench

//   Multi-cycle unsigned 16x16 -> 32-bit radix-2 shift-add multiplier.

---
 rtl/seq_shift_add_multiplier.sv | 144 ++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned 16x16 -> 32 radix-2 shift-add multiplier built around a carry-skip adder.
// Optional zero-operand shortcut enabled by defining SEQ_MUL_ZERO_BYPASS_EN.
`timescale 1ns/1ps

module skip_carry_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        co
);
  logic [4:0]  blk_c;
  logic        rc;
  logic        blk_p;
  logic        bit_p;

  // Four 4-bit ripple blocks; a block whose bits all propagate passes its carry-in straight through.
  always_comb begin
    s        = '0;
    blk_c    = '0;
    rc       = 1'b0;
    blk_p    = 1'b0;
    bit_p    = 1'b0;
    blk_c[0] = cin;
    for (int blk = 0; blk < 4; blk++) begin
      rc    = blk_c[blk];
      blk_p = 1'b1;
      for (int i = 0; i < 4; i++) begin
        bit_p          = a[blk*4+i] ^ b[blk*4+i];
        s[blk*4+i]     = bit_p ^ rc;
        rc             = (a[blk*4+i] & b[blk*4+i]) | (bit_p & rc);
        blk_p          = blk_p & bit_p;
      end
      blk_c[blk+1] = blk_p ? blk_c[blk] : rc;
    end
    co = blk_c[4];
  end
endmodule

module seq_shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     q_q;
  logic [WIDTH-1:0]     h_q;
  logic [3:0]           cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 co;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 bypass_hit;

  assign addend = q_q[0] ? m_q : '0;

  skip_carry_adder u_adder (
    .a   (h_q),
    .b   (addend),
    .cin (1'b0),
    .s   (sum),
    .co  (co)
  );

  // The carry-out becomes the new H[15]; the partial sum can be 17 bits wide.
  assign acc_d = {co, sum, q_q[WIDTH-1:1]};

`ifdef SEQ_MUL_ZERO_BYPASS_EN
  assign bypass_hit = (a == '0) || (b == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      h_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (bypass_hit) begin
              product_q <= '0;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end else begin
              m_q     <= a;
              q_q     <= b;
              h_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          h_q   <= acc_d[2*WIDTH-1:WIDTH];
          q_q   <= acc_d[WIDTH-1:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            product_q <= acc_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random back-to-back ops.
`timescale 1ns/1ps

module tb_seq_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[8];

  seq_shift_add_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_in),
    .b       (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_latency(input logic [15:0] a, input logic [15:0] b);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
    if (a == 16'h0 || b == 16'h0) return 1;
`endif
    return 17;
  endfunction

  // Issue one start and follow it to its done pulse; inputs change right after acceptance.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p);
    int          lat;
    int          busy_n;
    bit          stable;
    bit          overlap;
    logic [31:0] prev;
    int          exp_lat;
    prev    = product;
    exp_lat = model_latency(a, b);
    lat     = 0;
    busy_n  = 0;
    stable  = 1'b1;
    overlap = 1'b0;
    start   = 1'b1;
    a_in    = a;
    b_in    = b;
    do begin
      wait_clk();
      if (lat == 0) begin
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
      end
      lat++;
      if (busy) busy_n++;
      if (busy && done) overlap = 1'b1;
      if (!done && product !== prev) stable = 1'b0;
    end while (!done && lat < 40);
    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_n), 32'(exp_lat - 1));
    chk("product", product, exp_p);
    chk("product_stable_before_done", {31'b0, stable}, 32'd1);
    chk("busy_done_overlap", {31'b0, overlap}, 32'd0);
    wait_clk();
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("product_held", product, exp_p);
  endtask

  initial begin
    int          n_done;
    logic [15:0] ra;
    logic [15:0] rb;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[3] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    vecs[4] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[5] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[6] = '{16'h00FF, 16'h0101, 32'h0000FFFF};
    vecs[7] = '{16'hABCD, 16'h0001, 32'h0000ABCD};

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 16'h0;
    b_in  = 16'h0;
    repeat (3) wait_clk();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_product", product, 32'd0);
    rst = 1'b0;
    wait_clk();

    for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Re-pulsed start during CALC must be ignored.
    start = 1'b1; a_in = 16'd7; b_in = 16'd9;
    wait_clk();
    start = 1'b0;
    repeat (4) wait_clk();
    start = 1'b1; a_in = 16'd2; b_in = 16'd2;
    wait_clk();
    start = 1'b0;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      wait_clk();
      if (done) begin
        n_done++;
        chk("repulse_product", product, 32'd63);
      end
    end
    chk("repulse_single_done", 32'(n_done), 32'd1);
    chk("repulse_product_held", product, 32'd63);

    // Reset mid-CALC drops the operation.
    start = 1'b1; a_in = 16'h1234; b_in = 16'h5678;
    wait_clk();
    start = 1'b0;
    repeat (7) wait_clk();
    chk("pre_reset_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    wait_clk();
    rst = 1'b0;
    chk("midcalc_rst_busy", {31'b0, busy}, 32'd0);
    chk("midcalc_rst_done", {31'b0, done}, 32'd0);
    chk("midcalc_rst_product", product, 32'd0);
    n_done = 0;
    for (int k = 0; k < 25; k++) begin
      wait_clk();
      if (done || busy) n_done++;
    end
    chk("no_activity_after_rst", 32'(n_done), 32'd0);
    run_op(16'h1234, 16'h5678, 32'h1234 * 32'h5678);

    // Random back-to-back operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ((i % 37) == 0) ra = 16'h0;
      if ((i % 41) == 0) rb = 16'h0;
      if ((i % 29) == 0) begin ra = 16'hFFFF; rb = 16'($urandom_range(65535, 60000)); end
      run_op(ra, rb, 32'(ra) * 32'(rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
